// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem request,
// and presents one fetched PC+4/instruction pair to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCout,
  output logic [31:0] instOut,
  output logic        inst_valid,
  output logic        flush_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_discard;
  logic [31:0] r_inst_buf;
  logic [31:0] r_pc4_buf;

  logic [31:0] w_branch_tgt;
  logic [31:0] w_req_pc4;

  assign w_branch_tgt = branch_addr & ~32'h0000_0003;
  assign w_req_pc4    = r_req_addr + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= 32'd0;
      r_discard  <= 1'b0;
      r_inst_buf <= 32'd0;
      r_pc4_buf  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A request accepted in a branch cycle targets the old path; its response must be dropped.
          if (imem_ready) begin
            r_req_addr <= r_pc;
            r_state    <= S_WAIT;
            if (branch_taken) begin
              r_discard <= 1'b1;
            end
          end
          if (branch_taken) begin
            r_pc <= w_branch_tgt;
          end
        end
        S_WAIT: begin
          if (branch_taken) begin
            r_pc <= w_branch_tgt;
            if (imem_rvalid) begin
              r_discard <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_discard <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_inst_buf <= imem_rdata;
              r_pc4_buf  <= w_req_pc4;
              r_pc       <= w_req_pc4;
              r_state    <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (branch_taken) begin
            r_pc    <= w_branch_tgt;
            r_state <= S_IDLE;
          end else if (!freeze) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (r_state == S_IDLE);
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == S_FULL);
  assign instOut    = inst_valid ? r_inst_buf : 32'd0;
  assign PCout      = inst_valid ? r_pc4_buf : 32'd0;
  assign flush_out  = branch_taken;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, reset corner sequence,
// then randomized traffic against an outcome-level reference model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCout;
  logic [31:0] instOut;
  logic        inst_valid;
  logic        flush_out;

  int checks;
  int failures;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .PCout        (PCout),
    .instOut      (instOut),
    .inst_valid   (inst_valid),
    .flush_out    (flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] ba;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] ba,
                              input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.frz = frz; v.br = br; v.ba = ba; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_vld, input logic [31:0] e_inst, input logic [31:0] e_pc,
                          input logic e_flush);
    chk({tag, ".imem_req"},   {31'd0, imem_req},   {31'd0, e_req});
    chk({tag, ".imem_addr"},  imem_addr,           e_addr);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_vld});
    chk({tag, ".instOut"},    instOut,             e_inst);
    chk({tag, ".PCout"},      PCout,               e_pc);
    chk({tag, ".flush_out"},  {31'd0, flush_out},  {31'd0, e_flush});
  endtask

  task automatic drive(input logic frz, input logic br, input logic [31:0] ba,
                       input logic rdy, input logic rv, input logic [31:0] rd);
    freeze = frz; branch_taken = br; branch_addr = ba;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
  endtask

  // Reference model: tracks only what the fetch stage promises, in outcome terms.
  logic [31:0] m_pc, m_addr, m_inst, m_pc4;
  bit          m_pending, m_stale, m_present;
  int          mem_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0;
    m_pending = 0; m_stale = 0; m_present = 0; mem_cnt = 0;
  endtask

  task automatic model_edge(input logic frz, input logic br, input logic [31:0] ba,
                            input logic rdy, input logic rv, input logic [31:0] rd);
    logic [31:0] tgt;
    tgt = {ba[31:2], 2'b00};
    if (m_present) begin
      if (br) begin m_pc = tgt; m_present = 0; end
      else if (!frz) m_present = 0;
    end else if (m_pending) begin
      if (br) begin
        m_pc = tgt;
        if (rv) begin m_pending = 0; m_stale = 0; end
        else m_stale = 1;
      end else if (rv) begin
        m_pending = 0;
        if (m_stale) m_stale = 0;
        else begin
          m_inst = rd; m_pc4 = m_addr + 32'd4; m_pc = m_pc4; m_present = 1;
        end
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end
    end else begin
      if (rdy) begin
        m_addr = m_pc; m_pending = 1; mem_cnt = $urandom_range(0, 2);
        if (br) m_stale = 1;
      end
      if (br) m_pc = tgt;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    chk_outs("reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    tv[0]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    tv[1]  = mk(0, 0, 32'h0,        0, 1, 32'h2001_0005, 0, 32'h0,        0, 32'h0,        32'h0);
    tv[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        1, 32'h2001_0005, 32'h4);
    tv[3]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
    tv[4]  = mk(0, 0, 32'h0,        0, 1, 32'h1111_1111, 0, 32'h4,        0, 32'h0,        32'h0);
    tv[5]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        1, 32'h1111_1111, 32'h8);
    tv[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        1, 32'h1111_1111, 32'h8);
    tv[7]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        1, 32'h1111_1111, 32'h8);
    tv[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        1, 32'h1111_1111, 32'h8);
    tv[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    tv[10] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    tv[11] = mk(0, 1, 32'h103,      0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        32'h0);
    tv[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        32'h0);
    tv[13] = mk(0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 0, 32'h100,      0, 32'h0,        32'h0);
    tv[14] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
    tv[15] = mk(0, 1, 32'h200,      0, 1, 32'h2222_2222, 0, 32'h100,      0, 32'h0,        32'h0);
    tv[16] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0);
    tv[17] = mk(0, 0, 32'h0,        0, 1, 32'h3333_3333, 0, 32'h200,      0, 32'h0,        32'h0);
    tv[18] = mk(1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       0, 32'h204,      1, 32'h3333_3333, 32'h204);
    tv[19] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    tv[20] = mk(0, 0, 32'h0,        0, 1, 32'h4444_4444, 0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    tv[21] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h4444_4444, 32'h0);
    tv[22] = mk(0, 0, 32'h0,        0, 1, 32'h5555_5555, 1, 32'h0,        0, 32'h0,        32'h0);
    tv[23] = mk(0, 1, 32'h300,      1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    tv[24] = mk(0, 0, 32'h0,        0, 1, 32'h6666_6666, 0, 32'h300,      0, 32'h0,        32'h0);
    tv[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h300,      0, 32'h0,        32'h0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tv[i].frz, tv[i].br, tv[i].ba, tv[i].rdy, tv[i].rv, tv[i].rd);
      #1;
      chk_outs($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_vld,
               tv[i].e_inst, tv[i].e_pc, tv[i].br);
    end

    // Reset asserted while a request is outstanding, then a late response.
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    chk_outs("rst_wait_pre", 1'b0, 32'h300, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk_outs("rst_async", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 1, 32'h7777_7777);
    #1;
    chk_outs("rst_late_rv", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #1;
    chk_outs("rst_first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 32'h0BAD_F00D);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    chk_outs("rst_refetch", 1'b0, 32'h4, 1'b1, 32'h0BAD_F00D, 32'h4, 1'b0);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        f, b, r, v;
      logic [31:0] a, d;
      @(negedge clk);
      f = ($urandom % 4) == 0;
      b = ($urandom % 8) == 0;
      a = $urandom;
      r = $urandom % 2;
      d = $urandom;
      if (m_pending) v = (mem_cnt == 0);
      else v = ($urandom % 8) == 0;
      drive(f, b, a, r, v, d);
      #1;
      chk_outs($sformatf("rnd%0d", c), !m_pending && !m_present, m_pc, m_present,
               m_present ? m_inst : 32'h0, m_present ? m_pc4 : 32'h0, b);
      @(posedge clk);
      model_edge(f, b, a, r, v, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
